// File: rtl/spi_slave_pkg.sv
// Shared types and limits for the SPI slave clock-domain-crossing logic.
package spi_slave_pkg;

    // Address hand-off state: nothing pending / capture waiting for ack.
    typedef enum logic {
        ADDR_IDLE = 1'b0,
        ADDR_PEND = 1'b1
    } addr_state_e;

    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;

endpackage : spi_slave_pkg

// File: rtl/spi_slave_sync_cell.sv
// Single-bit multi-flop synchroniser into the sys_clk domain.
// Ports:
//   sys_clk - destination clock
//   rstn    - asynchronous active-low reset (all stages load RESET_VAL)
//   d       - asynchronous input bit
//   q       - synchronised bit, valid STAGES-1 edges after the first sampling edge
module spi_slave_sync_cell #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic sys_clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift chain; index 0 is the metastability-exposed sampling flop.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule : spi_slave_sync_cell

// File: rtl/spi_slave_syncro_hs.sv
// SPI-to-sys_clk crossing for the SPI slave: synchronises cs, address_valid
// and rd_wr, generates transaction start/end pulses, captures the address on
// a synchronised address_valid rising edge and offers it over req/ack with a
// sticky overrun flag.
// Optional build macro: SPI_SYNC_CS_FILTER_EN adds a FILTER_LEN-sample glitch
// filter on the synchronised cs.
// Ports:
//   sys_clk, rstn              - clock, asynchronous active-low reset
//   cs                         - SPI chip select (active low, async)
//   address, rd_wr             - SPI-domain payload, stable while address_valid
//   address_valid              - SPI-domain address valid level (async)
//   cs_sync                    - synchronised (optionally filtered) cs
//   cs_start_p / cs_end_p      - one-cycle pulses on cs_sync fall / rise
//   address_valid_sync         - synchronised address_valid
//   rd_wr_sync                 - synchronised rd_wr
//   addr_req, addr_q, rd_wr_q  - pending capture and its payload
//   addr_ack                   - consumer accepts the pending capture
//   addr_overrun               - sticky, capture dropped while pending
module spi_slave_syncro_hs
    import spi_slave_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_LEN     = 3
) (
    input  logic                      sys_clk,
    input  logic                      rstn,
    input  logic                      cs,
    input  logic [AXI_ADDR_WIDTH-1:0] address,
    input  logic                      address_valid,
    input  logic                      rd_wr,
    output logic                      cs_sync,
    output logic                      cs_start_p,
    output logic                      cs_end_p,
    output logic                      address_valid_sync,
    output logic                      rd_wr_sync,
    output logic                      addr_req,
    output logic [AXI_ADDR_WIDTH-1:0] addr_q,
    output logic                      rd_wr_q,
    input  logic                      addr_ack,
    output logic                      addr_overrun
);

    // Elaboration-time parameter checks.
    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
        $error("SYNC_STAGES out of range");
    end
    if (FILTER_LEN < 1) begin : g_bad_filter
        $error("FILTER_LEN must be at least 1");
    end

    logic cs_last;
    logic prev_cs;
    logic prev_valid;
    logic vld_rise;

    addr_state_e state_q;
    addr_state_e state_d;
    logic        capture;
    logic        overrun_evt;

    // Synchronisers; cs idles high so its chain resets to 1.
    spi_slave_sync_cell #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .sys_clk (sys_clk),
        .rstn    (rstn),
        .d       (cs),
        .q       (cs_last)
    );

    spi_slave_sync_cell #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_vld (
        .sys_clk (sys_clk),
        .rstn    (rstn),
        .d       (address_valid),
        .q       (address_valid_sync)
    );

    spi_slave_sync_cell #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_rw (
        .sys_clk (sys_clk),
        .rstn    (rstn),
        .d       (rd_wr),
        .q       (rd_wr_sync)
    );

`ifdef SPI_SYNC_CS_FILTER_EN
    localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

    logic [CNT_W-1:0] flt_cnt;
    logic             cs_flt;

    // cs_sync only follows the synchroniser after FILTER_LEN consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            flt_cnt <= '0;
            cs_flt  <= 1'b1;
        end else if (cs_last == cs_flt) begin
            flt_cnt <= '0;
        end else if (flt_cnt == CNT_W'(FILTER_LEN - 1)) begin
            flt_cnt <= '0;
            cs_flt  <= cs_last;
        end else begin
            flt_cnt <= flt_cnt + CNT_W'(1);
        end
    end

    assign cs_sync = cs_flt;
`else
    assign cs_sync = cs_last;
`endif

    // Previous-value registers for edge detection.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            prev_cs    <= 1'b1;
            prev_valid <= 1'b0;
        end else begin
            prev_cs    <= cs_sync;
            prev_valid <= address_valid_sync;
        end
    end

    // Edges decoded purely from flops, so each pulse lasts exactly one cycle.
    assign cs_start_p = prev_cs & ~cs_sync;
    assign cs_end_p   = ~prev_cs & cs_sync;
    assign vld_rise   = address_valid_sync & ~prev_valid;

    // Hand-off FSM state register.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ADDR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus capture/overrun decisions.
    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        overrun_evt = 1'b0;
        case (state_q)
            ADDR_IDLE: begin
                if (vld_rise) begin
                    capture = 1'b1;
                    state_d = ADDR_PEND;
                end
            end
            ADDR_PEND: begin
                // A new capture arriving with the ack replaces the accepted one.
                if (vld_rise && addr_ack) begin
                    capture = 1'b1;
                end else if (vld_rise) begin
                    overrun_evt = 1'b1;
                end else if (addr_ack) begin
                    state_d = ADDR_IDLE;
                end
            end
            default: state_d = ADDR_IDLE;
        endcase
    end

    assign addr_req = (state_q == ADDR_PEND);

    // Payload capture; raw address is only ever sampled here.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            addr_q  <= '0;
            rd_wr_q <= 1'b0;
        end else if (capture) begin
            addr_q  <= address;
            rd_wr_q <= rd_wr;
        end
    end

    // Sticky overrun, cleared at transaction start; a new overrun wins.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            addr_overrun <= 1'b0;
        end else if (overrun_evt) begin
            addr_overrun <= 1'b1;
        end else if (cs_start_p) begin
            addr_overrun <= 1'b0;
        end
    end

endmodule : spi_slave_syncro_hs

// File: tb/tb_spi_slave_syncro_hs.sv
// Self-checking bench for spi_slave_syncro_hs: directed scenarios followed
// by randomized transactions, with accepted captures checked by a scoreboard.
module tb_spi_slave_syncro_hs;

    localparam int unsigned AW = 32;
    localparam int unsigned S  = 2;
    localparam int unsigned FL = 3;
`ifdef SPI_SYNC_CS_FILTER_EN
    localparam int unsigned CS_LAT = S - 1 + FL;
`else
    localparam int unsigned CS_LAT = S - 1;
`endif

    logic          sys_clk = 1'b0;
    logic          rstn    = 1'b0;
    logic          cs      = 1'b0;
    logic [AW-1:0] address = '0;
    logic          address_valid = 1'b0;
    logic          rd_wr   = 1'b0;
    logic          addr_ack = 1'b0;
    logic          cs_sync, cs_start_p, cs_end_p;
    logic          address_valid_sync, rd_wr_sync;
    logic          addr_req, rd_wr_q, addr_overrun;
    logic [AW-1:0] addr_q;

    spi_slave_syncro_hs #(
        .AXI_ADDR_WIDTH (AW),
        .SYNC_STAGES    (S),
        .FILTER_LEN     (FL)
    ) dut (
        .sys_clk            (sys_clk),
        .rstn               (rstn),
        .cs                 (cs),
        .address            (address),
        .address_valid      (address_valid),
        .rd_wr              (rd_wr),
        .cs_sync            (cs_sync),
        .cs_start_p         (cs_start_p),
        .cs_end_p           (cs_end_p),
        .address_valid_sync (address_valid_sync),
        .rd_wr_sync         (rd_wr_sync),
        .addr_req           (addr_req),
        .addr_q             (addr_q),
        .rd_wr_q            (rd_wr_q),
        .addr_ack           (addr_ack),
        .addr_overrun       (addr_overrun)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          rw;
    } cap_t;

    cap_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one pending slot, sticky overrun, transaction counts.
    bit            m_pend = 0;
    bit            m_ovr  = 0;
    logic [AW-1:0] m_addr = '0;
    logic          m_rw   = 1'b0;
    int            m_starts = 0;
    int            m_ends   = 0;
    int            seen_starts = 0;
    int            seen_ends   = 0;
    logic          last_start = 1'b0;
    logic          last_end   = 1'b0;

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: a capture is consumed whenever req and ack meet.
    always @(negedge sys_clk) begin
        if (!rstn) begin
            last_start = 1'b0;
            last_end   = 1'b0;
        end else begin
            if (addr_req && addr_ack) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_underflow: got unexpected accept of 0x%0h expected none", addr_q);
                end else begin
                    cap_t e;
                    e = exp_q.pop_front();
                    chk("sb_addr", addr_q, e.addr);
                    chk("sb_rw", AW'(rd_wr_q), AW'(e.rw));
                end
            end
            if (cs_start_p) begin
                seen_starts++;
                chk("start_p_width", AW'(last_start), '0);
            end
            if (cs_end_p) begin
                seen_ends++;
                chk("end_p_width", AW'(last_end), '0);
            end
            last_start = cs_start_p;
            last_end   = cs_end_p;
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // One address_valid pulse; optionally ack lands on the same edge as vld_rise.
    task automatic issue(input logic [AW-1:0] a, input logic rw, input bit ack_at_rise);
        cap_t c;
        address       = a;
        rd_wr         = rw;
        address_valid = 1'b1;
        ticks(S);
        chk("pre_capture_req", AW'(addr_req), AW'(m_pend));
        if (ack_at_rise) addr_ack = 1'b1;
        tick();
        addr_ack = 1'b0;
        c.addr = a;
        c.rw   = rw;
        if (!m_pend || ack_at_rise) begin
            exp_q.push_back(c);
            m_pend = 1;
            m_addr = a;
            m_rw   = rw;
        end else begin
            m_ovr = 1;
        end
        chk("issue_req", AW'(addr_req), AW'(m_pend));
        chk("issue_addr", addr_q, m_addr);
        chk("issue_rw", AW'(rd_wr_q), AW'(m_rw));
        chk("issue_ovr", AW'(addr_overrun), AW'(m_ovr));
        address_valid = 1'b0;
        address       = $urandom;
        rd_wr         = 1'($urandom_range(0, 1));
        ticks(S + 1);
    endtask

    task automatic do_ack();
        addr_ack = 1'b1;
        tick();
        addr_ack = 1'b0;
        m_pend = 0;
        chk("ack_req_low", AW'(addr_req), '0);
    endtask

    // End the transaction and start a new one; overrun clears on the start.
    task automatic cs_cycle();
        cs = 1'b1;
        ticks(CS_LAT + 2);
        m_ends++;
        chk("cs_high", AW'(cs_sync), AW'(1));
        chk("req_survives_end", AW'(addr_req), AW'(m_pend));
        cs = 1'b0;
        ticks(CS_LAT + 2);
        m_starts++;
        m_ovr = 0;
        chk("cs_low", AW'(cs_sync), '0);
        chk("ovr_cleared", AW'(addr_overrun), '0);
    endtask

    initial begin
        logic [AW-1:0] a, b;
        logic          rw, rw2;
        int            mode;

        // Reset with cs asserted and address_valid high.
        rstn = 1'b0;
        cs = 1'b0;
        address_valid = 1'b1;
        address = 32'h0000_0055;
        rd_wr = 1'b0;
        ticks(3);
        chk("rst_cs_sync", AW'(cs_sync), AW'(1));
        chk("rst_req", AW'(addr_req), '0);
        chk("rst_addr_q", addr_q, '0);
        chk("rst_start_p", AW'(cs_start_p), '0);
        chk("rst_ovr", AW'(addr_overrun), '0);

        rstn = 1'b1;
        exp_q.push_back(cap_t'{addr: 32'h0000_0055, rw: 1'b0});
        m_starts++;
        ticks(CS_LAT);
        chk("cs_before_lat", AW'(cs_sync), AW'(1));
        tick();
        chk("cs_after_lat", AW'(cs_sync), '0);
        chk("start_p_high", AW'(cs_start_p), AW'(1));
        tick();
        chk("start_p_low", AW'(cs_start_p), '0);
        address_valid = 1'b0;
        ticks(S + 1);
        m_pend = 1;
        m_addr = 32'h0000_0055;
        m_rw   = 1'b0;
        chk("rst_capture_req", AW'(addr_req), AW'(1));
        chk("rst_capture_addr", addr_q, m_addr);
        do_ack();

        // Basic capture and acknowledge.
        issue(32'h1000_0040, 1'b1, 0);
        do_ack();

        // Overrun: second capture dropped, cleared by next transaction start.
        issue(32'h0000_00A0, 1'b0, 0);
        issue(32'h0000_00B0, 1'b1, 0);
        cs_cycle();
        do_ack();

        // Ack coinciding with a new capture.
        issue(32'h0000_0011, 1'b0, 0);
        issue(32'h0000_00C4, 1'b1, 1);
        do_ack();

        // Reset while a request is pending.
        issue(32'h0000_0077, 1'b1, 0);
        rstn = 1'b0;
        #1;
        chk("mid_rst_req", AW'(addr_req), '0);
        chk("mid_rst_cs_sync", AW'(cs_sync), AW'(1));
        void'(exp_q.pop_back());
        m_pend = 0;
        m_ovr  = 0;
        m_addr = '0;
        m_rw   = 1'b0;
        tick();
        rstn = 1'b1;
        m_starts++;
        ticks(CS_LAT + 3);
        chk("post_rst_cs_sync", AW'(cs_sync), '0);

`ifdef SPI_SYNC_CS_FILTER_EN
        // Short cs glitch is suppressed; a held cs low passes after FL cycles.
        cs = 1'b1;
        ticks(CS_LAT + 2);
        m_ends++;
        cs = 1'b0;
        ticks(2);
        cs = 1'b1;
        ticks(CS_LAT + 4);
        chk("glitch_cs_sync", AW'(cs_sync), AW'(1));
        cs = 1'b0;
        ticks(CS_LAT);
        chk("filt_cs_before", AW'(cs_sync), AW'(1));
        tick();
        chk("filt_cs_after", AW'(cs_sync), '0);
        m_starts++;
        ticks(2);
`endif

        // Randomized traffic.
        for (int i = 0; i < 24; i++) begin
            a    = $urandom;
            b    = $urandom;
            rw   = 1'($urandom_range(0, 1));
            rw2  = 1'($urandom_range(0, 1));
            mode = int'($urandom_range(0, 3));
            case (mode)
                0: begin
                    issue(a, rw, 0);
                    ticks(int'($urandom_range(0, 3)));
                    do_ack();
                end
                1: begin
                    issue(a, rw, 0);
                    issue(b, rw2, 0);
                    if ($urandom_range(0, 1) == 1) cs_cycle();
                    do_ack();
                end
                2: begin
                    issue(a, rw, 0);
                    issue(b, rw2, 1);
                    do_ack();
                end
                default: begin
                    issue(a, rw, 0);
                    cs_cycle();
                    do_ack();
                end
            endcase
        end

        ticks(5);
        chk("start_count", AW'(seen_starts), AW'(m_starts));
        chk("end_count", AW'(seen_ends), AW'(m_ends));
        chk("sb_leftover", AW'(exp_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_spi_slave_syncro_hs
